// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 16x oversampling tick, two-flop input
// synchroniser and registered done / framing-error strobes.
module uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int NB_BITS    = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx,
    output logic [NB_BITS-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW       = $clog2(TICK_DIV);
    localparam int NW       = (NB_BITS > 1) ? $clog2(NB_BITS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(NB_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rxS;

    logic [TW-1:0]        r_tickCnt;
    logic                 w_tick;

    logic [3:0]           r_s;
    logic [3:0]           w_sNext;
    logic [NW-1:0]        r_n;
    logic [NW-1:0]        w_nNext;
    logic [NB_BITS-1:0]   r_sh;
    logic [NB_BITS-1:0]   w_shNext;

    logic [NB_BITS-1:0]   r_data;
    logic [NB_BITS-1:0]   w_dataNext;
    logic                 r_rxDone;
    logic                 w_doneNext;
    logic                 r_frameErr;
    logic                 w_errNext;

    // Two-flop synchroniser; both stages reset to the idle-high line level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxS = r_sync2;

    // Free-running oversample tick divider; a start edge does not restart it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tickCnt <= '0;
        end else if (w_tick) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + 1'b1;
        end
    end

    assign w_tick = (r_tickCnt == TICK_LAST);

    // State, counters, shift register and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_s        <= '0;
            r_n        <= '0;
            r_sh       <= '0;
            r_data     <= '0;
            r_rxDone   <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_s        <= w_sNext;
            r_n        <= w_nNext;
            r_sh       <= w_shNext;
            r_data     <= w_dataNext;
            r_rxDone   <= w_doneNext;
            r_frameErr <= w_errNext;
        end
    end

    // Deframing: sample the start bit mid-bit, then every 16 ticks after it.
    always_comb begin
        w_stateNext = r_state;
        w_sNext     = r_s;
        w_nNext     = r_n;
        w_shNext    = r_sh;
        w_dataNext  = r_data;
        w_doneNext  = 1'b0;
        w_errNext   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxS) begin
                    w_stateNext = START;
                    w_sNext     = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s == 4'd7) begin
                        if (!w_rxS) begin
                            w_stateNext = DATA;
                            w_sNext     = '0;
                            w_nNext     = '0;
                        end else begin
                            w_stateNext = IDLE;
                        end
                    end else begin
                        w_sNext = r_s + 4'd1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_sNext = r_s + 4'd1;
                    if (r_s == 4'd15) begin
                        w_shNext = {w_rxS, r_sh[NB_BITS-1:1]};
                        if (r_n == N_LAST) begin
                            w_nNext     = '0;
                            w_stateNext = STOP;
                        end else begin
                            w_nNext = r_n + 1'b1;
                        end
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_sNext = r_s + 4'd1;
                    if (r_s == 4'd15) begin
                        if (w_rxS) begin
                            w_dataNext = r_sh;
                            w_doneNext = 1'b1;
                        end else begin
                            w_errNext = 1'b1;
                        end
                        w_stateNext = IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign o_data      = r_data;
    assign o_rx_done   = r_rxDone;
    assign o_frame_err = r_frameErr;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a frame-level expectation queue.
module tb_uart_rx;

    localparam int CLK_FREQ  = 1_600_000;
    localparam int BAUD_RATE = 10_000;
    localparam int NB_BITS   = 8;
    localparam int BIT_CLKS  = 160;
    localparam int LAT_MIN   = 1510;
    localparam int LAT_MAX   = 1530;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [7:0]  data;
    logic        done;
    logic        err;
    logic        busy;

    typedef struct {
        bit         good;
        logic [7:0] data;
        int         startCycle;
    } frame_t;

    frame_t     expQ[$];
    logic [7:0] expData = 8'h00;
    int         assertCount = 0;
    int         failCount = 0;
    int         cycle = 0;
    int         doneCount = 0;
    int         errCount = 0;
    int         busyCycles = 0;
    int         lastDoneCycle = 0;
    int         prevDoneCycle = 0;
    bit         rstSampled = 1'b0;
    int         d0;
    int         e0;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .NB_BITS   (NB_BITS),
        .OVERSAMPLE(16)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx       (rx),
        .o_data     (data),
        .o_rx_done  (done),
        .o_frame_err(err),
        .o_busy     (busy)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    // Cycle count and the reset level the DUT saw at this edge.
    always @(posedge clk) begin
        cycle      <= cycle + 1;
        rstSampled <= rst;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        assertCount++;
        if (actual < lo || actual > hi) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One ideal 8N1 frame; the stop level is held for stopLen clocks, then the line idles.
    task automatic applyStimulus(input logic [7:0] d, input bit stopVal, input int stopLen);
        frame_t f;
        f.good       = stopVal;
        f.data       = d;
        f.startCycle = cycle;
        expQ.push_back(f);
        rx = 1'b0;
        waitCycles(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            waitCycles(BIT_CLKS);
        end
        rx = stopVal;
        waitCycles(stopLen);
        rx = 1'b1;
        if (stopLen < BIT_CLKS) waitCycles(BIT_CLKS - stopLen);
    endtask

    // Every cycle: reset values, pulse legality and timing, and the held word.
    always @(negedge clk) begin : compare
        frame_t f;
        if (rstSampled) begin
            expQ.delete();
            expData = 8'h00;
            checkOutput("rstData", {24'b0, data}, 32'h0);
            checkOutput("rstDone", {31'b0, done}, 32'h0);
            checkOutput("rstErr", {31'b0, err}, 32'h0);
            checkOutput("rstBusy", {31'b0, busy}, 32'h0);
        end else begin
            checkOutput("pulseExclusive", {31'b0, done & err}, 32'h0);
            if (busy) busyCycles++;
            if (done || err) begin
                if (done) begin
                    doneCount++;
                    prevDoneCycle = lastDoneCycle;
                    lastDoneCycle = cycle;
                end
                if (err) errCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedPulse", {30'b0, done, err}, 32'h0);
                end else begin
                    f = expQ.pop_front();
                    checkOutput("pulseKind", {31'b0, done}, {31'b0, f.good});
                    checkRange("pulseLatency", cycle - f.startCycle, LAT_MIN, LAT_MAX);
                    if (f.good) expData = f.data;
                end
            end else if (expQ.size() > 0 && (cycle - expQ[0].startCycle) > LAT_MAX) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL missingPulse: got no pulse, expected one within %0d clk", LAT_MAX);
                void'(expQ.pop_front());
            end
            checkOutput("dataHold", {24'b0, data}, {24'b0, expData});
        end
    end

    // Directed scenario sequence.
    initial begin
        rx  = 1'b1;
        rst = 1'b1;
        waitCycles(5);
        rst = 1'b0;

        $display("[TB] idle after reset");
        waitCycles(2000);
        checkOutput("idleDone", doneCount, 0);
        checkOutput("idleErr", errCount, 0);
        checkOutput("idleBusy", {31'b0, busy}, 32'h0);

        $display("[TB] single frame 0x55");
        d0 = doneCount;
        busyCycles = 0;
        applyStimulus(8'h55, 1'b1, BIT_CLKS);
        checkOutput("singleData", {24'b0, data}, 32'h55);
        checkOutput("singleModel", {24'b0, expData}, 32'h55);
        checkOutput("singleDoneCnt", doneCount - d0, 1);
        checkOutput("singleErrCnt", errCount, 0);
        checkOutput("singleBusyEnd", {31'b0, busy}, 32'h0);
        checkRange("singleBusyLen", busyCycles, 1500, 1530);
        waitCycles(100);

        $display("[TB] back-to-back 0xA3, 0x0F");
        d0 = doneCount;
        applyStimulus(8'hA3, 1'b1, BIT_CLKS);
        checkOutput("b2bFirstData", {24'b0, data}, 32'hA3);
        applyStimulus(8'h0F, 1'b1, BIT_CLKS);
        checkOutput("b2bSecondData", {24'b0, data}, 32'h0F);
        checkOutput("b2bDoneCnt", doneCount - d0, 2);
        checkRange("b2bSpacing", lastDoneCycle - prevDoneCycle, 1590, 1610);
        waitCycles(100);

        $display("[TB] 40-clk glitch");
        d0 = doneCount;
        e0 = errCount;
        busyCycles = 0;
        rx = 1'b0;
        waitCycles(40);
        rx = 1'b1;
        waitCycles(200);
        checkRange("glitchBusyLen", busyCycles, 1, 90);
        checkOutput("glitchDoneCnt", doneCount - d0, 0);
        checkOutput("glitchErrCnt", errCount - e0, 0);
        checkOutput("glitchData", {24'b0, data}, 32'h0F);

        $display("[TB] framing error after 0x3C");
        applyStimulus(8'h3C, 1'b1, BIT_CLKS);
        waitCycles(100);
        d0 = doneCount;
        e0 = errCount;
        // Stop level released early so the re-arm after the error sees only a glitch.
        applyStimulus(8'hFF, 1'b0, 100);
        waitCycles(200);
        checkOutput("ferrErrCnt", errCount - e0, 1);
        checkOutput("ferrDoneCnt", doneCount - d0, 0);
        checkOutput("ferrData", {24'b0, data}, 32'h3C);
        checkOutput("ferrBusy", {31'b0, busy}, 32'h0);

        $display("[TB] reset during data bit 4 of 0x81");
        d0 = doneCount;
        e0 = errCount;
        rx = 1'b0;
        waitCycles(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0) ? 1'b1 : 1'b0;
            waitCycles(BIT_CLKS);
        end
        rx = 1'b0;
        waitCycles(BIT_CLKS / 2);
        rst = 1'b1;
        rx  = 1'b1;
        waitCycles(5);
        rst = 1'b0;
        waitCycles(300);
        checkOutput("abortData", {24'b0, data}, 32'h00);
        checkOutput("abortDoneCnt", doneCount - d0, 0);
        checkOutput("abortErrCnt", errCount - e0, 0);
        checkOutput("abortBusy", {31'b0, busy}, 32'h0);
        applyStimulus(8'h7E, 1'b1, BIT_CLKS);
        waitCycles(100);
        checkOutput("recoverData", {24'b0, data}, 32'h7E);
        checkOutput("recoverDoneCnt", doneCount - d0, 1);

        waitCycles(100);
        checkOutput("pendingFrames", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
